// File: rtl/flit_packetizer_pkg.sv
// Flit type tags shared between the packetizer and the downstream virtual
// channel decoder. Tag value 0 is left unused so an idle/cleared bus never
// decodes as a valid flit type.
package flit_packetizer_pkg;

    localparam int unsigned FLIT_ID_W = 2;

    localparam logic [FLIT_ID_W-1:0] HEADER_ID = 2'b01;
    localparam logic [FLIT_ID_W-1:0] BODY_ID   = 2'b10;
    localparam logic [FLIT_ID_W-1:0] TAIL_ID   = 2'b11;

endpackage

// File: rtl/flit_packetizer.sv
// flit_packetizer: transmit end of a VC link. Accepts a packet request
// (header payload + payload length N) and a payload word stream, and writes
// a HEADER / BODY.. / TAIL flit sequence into a downstream VC FIFO, obeying
// its backpressure (rdy_i = ~full). N=0 packets are sent as HEADER then an
// empty TAIL flit.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   pkt_vld_i/pkt_rdy_o          packet request handshake
//   pkt_hdr_i, pkt_len_i         header payload, payload flit count
//   body_vld_i/body_rdy_o        payload word handshake
//   body_data_i                  payload word
//   data_o, wr_en_o              flit and write strobe to downstream VC
//   rdy_i                        downstream VC not full
//   pkt_cnt_o, stall_cnt_o       (PKTZ_STATS_EN only) tails sent, stalled cycles
//
// Build option: define PKTZ_STATS_EN to add the statistics counters/ports.
module flit_packetizer
    import flit_packetizer_pkg::*;
#(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ID_W   = 2,
    parameter int unsigned LEN_W  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pkt_vld_i,
    output logic                   pkt_rdy_o,
    input  logic [DATA_W-ID_W-1:0] pkt_hdr_i,
    input  logic [LEN_W-1:0]       pkt_len_i,
    input  logic                   body_vld_i,
    output logic                   body_rdy_o,
    input  logic [DATA_W-ID_W-1:0] body_data_i,
`ifdef PKTZ_STATS_EN
    output logic [15:0]            pkt_cnt_o,
    output logic [15:0]            stall_cnt_o,
`endif
    output logic [DATA_W-1:0]      data_o,
    output logic                   wr_en_o,
    input  logic                   rdy_i
);

    localparam int unsigned PAY_W = DATA_W - ID_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HEAD  = 2'd1;
    localparam logic [1:0] ST_BODY  = 2'd2;
    localparam logic [1:0] ST_ETAIL = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PAY_W-1:0] hdr_q, hdr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [ID_W-1:0]  tag;
    logic [PAY_W-1:0] payload;
    logic             wr;
    logic             last_body;

    assign last_body = (rem_q == LEN_W'(1));

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        rem_d      = rem_q;
        pkt_rdy_o  = 1'b0;
        body_rdy_o = 1'b0;
        wr         = 1'b0;
        tag        = '0;
        payload    = '0;
        unique case (state_q)
            ST_IDLE: begin
                pkt_rdy_o = 1'b1;
                if (pkt_vld_i) begin
                    hdr_d   = pkt_hdr_i;
                    rem_d   = pkt_len_i;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                tag     = ID_W'(HEADER_ID);
                payload = hdr_q;
                wr      = rdy_i & ~rst_i;
                if (wr) begin
                    state_d = (rem_q != '0) ? ST_BODY : ST_ETAIL;
                end
            end
            ST_BODY: begin
                tag        = last_body ? ID_W'(TAIL_ID) : ID_W'(BODY_ID);
                payload    = body_data_i;
                body_rdy_o = rdy_i & ~rst_i;
                wr         = body_vld_i & rdy_i & ~rst_i;
                if (wr) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (last_body) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ETAIL: begin
                // Empty tail closes a zero-length packet; body stream is left alone.
                tag = ID_W'(TAIL_ID);
                wr  = rdy_i & ~rst_i;
                if (wr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_en_o = wr;
    assign data_o  = {tag, payload};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            hdr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            rem_q   <= rem_d;
        end
    end

`ifdef PKTZ_STATS_EN
    logic        tail_sent;
    logic        stalled;
    logic [15:0] pkt_cnt_q;
    logic [15:0] stall_cnt_q;

    assign tail_sent = wr & ((state_q == ST_ETAIL) | ((state_q == ST_BODY) & last_body));
    // A stall is a cycle where a flit is ready to go but the VC is full.
    assign stalled   = ~rdy_i & ((state_q == ST_HEAD) | (state_q == ST_ETAIL) |
                                 ((state_q == ST_BODY) & body_vld_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (tail_sent) pkt_cnt_q <= pkt_cnt_q + 16'd1;
            if (stalled) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign pkt_cnt_o   = pkt_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    // Statistics disabled: no counters or ports.
`endif

endmodule

// File: tb/tb_flit_packetizer.sv
module tb_flit_packetizer;
    import flit_packetizer_pkg::*;

    localparam int unsigned DATA_W = 10;
    localparam int unsigned ID_W   = 2;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned PAY_W  = DATA_W - ID_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              pkt_vld;
    logic              pkt_rdy;
    logic [PAY_W-1:0]  pkt_hdr;
    logic [LEN_W-1:0]  pkt_len;
    logic              body_vld;
    logic              body_rdy;
    logic [PAY_W-1:0]  body_data;
    logic [DATA_W-1:0] data;
    logic              wr_en;
    logic              rdy;
`ifdef PKTZ_STATS_EN
    logic [15:0]       pkt_cnt;
    logic [15:0]       stall_cnt;
`endif

    flit_packetizer #(
        .DATA_W(DATA_W),
        .ID_W  (ID_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .pkt_vld_i  (pkt_vld),
        .pkt_rdy_o  (pkt_rdy),
        .pkt_hdr_i  (pkt_hdr),
        .pkt_len_i  (pkt_len),
        .body_vld_i (body_vld),
        .body_rdy_o (body_rdy),
        .body_data_i(body_data),
`ifdef PKTZ_STATS_EN
        .pkt_cnt_o  (pkt_cnt),
        .stall_cnt_o(stall_cnt),
`endif
        .data_o     (data),
        .wr_en_o    (wr_en),
        .rdy_i      (rdy)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] exp_q[$];
    logic [PAY_W-1:0]  body_q[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    logic              body_toggle = 1'b0;
    logic              body_gate = 1'b1;
    logic [DATA_W-1:0] exp_f;

    function automatic logic [DATA_W-1:0] flit(input logic [ID_W-1:0] id,
                                               input logic [PAY_W-1:0] p);
        return {id, p};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: every VC write must match the next expected flit.
    always @(negedge clk) begin
        if (wr_en) begin
            check("no_overflow", {31'd0, rdy}, 32'd1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got %0h, expected no write", data);
            end else begin
                exp_f = exp_q.pop_front();
                check("flit", {22'd0, data}, {22'd0, exp_f});
            end
        end
    end

    // Payload source: presents body_q head, pops on handshake.
    initial begin : body_drv
        logic hs;
        body_vld  = 1'b0;
        body_data = '0;
        forever begin
            @(negedge clk);
            hs = body_vld && body_rdy;
            @(posedge clk);
            #1;
            if (hs && body_q.size() > 0) void'(body_q.pop_front());
            if (body_toggle) body_gate = ~body_gate;
            else body_gate = 1'b1;
            body_vld  = (body_q.size() > 0) && body_gate;
            body_data = (body_q.size() > 0) ? body_q[0] : '0;
        end
    end

    // Returns one time unit after the accepting clock edge.
    task automatic send_pkt(input logic [PAY_W-1:0] hdr, input logic [LEN_W-1:0] len);
        int t;
        @(posedge clk);
        #1;
        pkt_vld = 1'b1;
        pkt_hdr = hdr;
        pkt_len = len;
        t = 0;
        forever begin
            @(negedge clk);
            if (pkt_rdy || t >= 50) break;
            t++;
        end
        if (t >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got pkt_rdy=0, expected acceptance");
        end
        @(posedge clk);
        #1;
        pkt_vld = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && pkt_rdy) && t < 200) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d flits outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_cnt;
        rst     = 1'b1;
        pkt_vld = 1'b0;
        pkt_hdr = '0;
        pkt_len = '0;
        rdy     = 1'b1;
        @(negedge clk);
        check("rst_cycle_wr", {31'd0, wr_en}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_pkt_rdy", {31'd0, pkt_rdy}, 32'd1);
        check("reset_body_rdy", {31'd0, body_rdy}, 32'd0);
        check("reset_wr_en", {31'd0, wr_en}, 32'd0);
        check("reset_data", {22'd0, data}, 32'd0);

        // 1: len=3, continuous flow
        body_q.push_back(8'hA1); body_q.push_back(8'hA2); body_q.push_back(8'hA3);
        exp_q.push_back(flit(HEADER_ID, 8'h35));
        exp_q.push_back(flit(BODY_ID, 8'hA1));
        exp_q.push_back(flit(BODY_ID, 8'hA2));
        exp_q.push_back(flit(TAIL_ID, 8'hA3));
        send_pkt(8'h35, 4'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_back_to_back_wr", {31'd0, wr_en}, 32'd1);
        end
        @(negedge clk);
        check("t1_pkt_rdy_after_tail", {31'd0, pkt_rdy}, 32'd1);
        drain();

        // 2: backpressure for 3 cycles after first body flit
        body_q.push_back(8'hA1); body_q.push_back(8'hA2); body_q.push_back(8'hA3);
        exp_q.push_back(flit(HEADER_ID, 8'h35));
        exp_q.push_back(flit(BODY_ID, 8'hA1));
        exp_q.push_back(flit(BODY_ID, 8'hA2));
        exp_q.push_back(flit(TAIL_ID, 8'hA3));
        send_pkt(8'h35, 4'd3);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_stall_wr", {31'd0, wr_en}, 32'd0);
            check("t2_stall_body_rdy", {31'd0, body_rdy}, 32'd0);
        end
        @(posedge clk);
        #1 rdy = 1'b1;
        drain();

        // 3: len=0 with a stray body word present that must not be consumed
        body_q.push_back(8'h77);
        exp_q.push_back(flit(HEADER_ID, 8'h0F));
        exp_q.push_back(flit(TAIL_ID, 8'h00));
        send_pkt(8'h0F, 4'd0);
        bad_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (body_rdy) bad_cnt++;
        end
        check("t3_body_rdy_never", bad_cnt, 0);
        drain();
        check("t3_body_untouched", body_q.size(), 1);
        body_q.delete();

        // 4: len=2 with toggling body valid
        body_toggle = 1'b1;
        body_q.push_back(8'h5B); body_q.push_back(8'hC4);
        exp_q.push_back(flit(HEADER_ID, 8'h4C));
        exp_q.push_back(flit(BODY_ID, 8'h5B));
        exp_q.push_back(flit(TAIL_ID, 8'hC4));
        send_pkt(8'h4C, 4'd2);
        bad_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wr_en && body_rdy && !body_vld) bad_cnt++;
        end
        check("t4_wr_only_with_vld", bad_cnt, 0);
        drain();
        body_toggle = 1'b0;

        // 5: reset in the middle of a len=5 packet
        for (int i = 1; i <= 5; i++) body_q.push_back(PAY_W'(i));
        exp_q.push_back(flit(HEADER_ID, 8'h5A));
        exp_q.push_back(flit(BODY_ID, 8'h01));
        exp_q.push_back(flit(BODY_ID, 8'h02));
        send_pkt(8'h5A, 4'd5);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t5_rst_wr", {31'd0, wr_en}, 32'd0);
        check("t5_rst_body_rdy", {31'd0, body_rdy}, 32'd0);
        body_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_pkt_rdy_after_rst", {31'd0, pkt_rdy}, 32'd1);
        check("t5_wr_after_rst", {31'd0, wr_en}, 32'd0);
        check("t5_truncated", exp_q.size(), 0);
        body_q.push_back(8'h99);
        exp_q.push_back(flit(HEADER_ID, 8'h2A));
        exp_q.push_back(flit(TAIL_ID, 8'h99));
        send_pkt(8'h2A, 4'd1);
        drain();

        // Zero-length packet stalled 4 cycles in HEAD
        rdy = 1'b0;
        exp_q.push_back(flit(HEADER_ID, 8'h11));
        exp_q.push_back(flit(TAIL_ID, 8'h00));
        send_pkt(8'h11, 4'd0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rdy = 1'b1;
        drain();

        body_q.push_back(8'hEE);
        exp_q.push_back(flit(HEADER_ID, 8'h22));
        exp_q.push_back(flit(TAIL_ID, 8'hEE));
        send_pkt(8'h22, 4'd1);
        drain();

`ifdef PKTZ_STATS_EN
        // 6: three packets since the last reset, four stalled cycles
        check("t6_pkt_cnt", {16'd0, pkt_cnt}, 32'd3);
        check("t6_stall_cnt", {16'd0, stall_cnt}, 32'd4);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_pkt_cnt_clr", {16'd0, pkt_cnt}, 32'd0);
        check("t6_stall_cnt_clr", {16'd0, stall_cnt}, 32'd0);
`endif

        repeat (2) @(negedge clk);
        check("all_flits_seen", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
